// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline-register chain.
`ifndef PIPE_PKG_SV
`define PIPE_PKG_SV

// One pipeline slot: a valid bit in front of a W-bit payload.
`define PIPE_STAGE_T(W) struct packed { logic valid; logic [(W)-1:0] data; }

package pipe_pkg;
    localparam int MAX_DEPTH = 64;
    localparam logic [MAX_DEPTH-1:0] FLUSH_NONE = '0;
    localparam logic [MAX_DEPTH-1:0] FLUSH_ALL  = '1;

    // Occupancy counts every stage plus the skid entry, so it must reach DEPTH+1.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 2);
    endfunction
endpackage

`endif

// File: rtl/pipe_skid_buf.sv
// One-entry input skid buffer; lets the chain present in_ready straight from a flop.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             kill_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);
    logic             full_q;
    logic             full_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        full_d = full_q ? !pop_i : push_i;
        if (kill_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            if (push_i) begin
                data_q <= data_i;
            end
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;
endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic, bubble-collapsing chain of DEPTH valid/data registers with selective
// flush, optional registered-ready skid entry, occupancy and drop statistics.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter bit REG_READY = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    input  logic                        out_ready,
    input  logic                        flush,
    input  logic [DEPTH-1:0]            flush_mask,
    output logic [occ_width(DEPTH)-1:0] occupancy,
    output logic [CNT_W-1:0]            drop_cnt
);
    localparam int OW = occ_width(DEPTH);
    typedef `PIPE_STAGE_T(WIDTH) stage_t;

    logic [DEPTH-1:0] v_q, v_d, v_nf, adv, kill;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    stage_t           src;
    logic             skid_full, skid_nf;
    logic [OW-1:0]    kill_n, occupancy_d, occupancy_q;
    logic [CNT_W:0]   drop_sum;
    logic [CNT_W-1:0] drop_cnt_d, drop_cnt_q;

    assign kill = flush ? flush_mask : FLUSH_NONE[DEPTH-1:0];

    // skid_nf is the skid occupancy the next edge would leave if nothing were flushed.
    generate
        if (REG_READY) begin : g_skid
            logic [WIDTH-1:0] skid_data;
            pipe_skid_buf #(.WIDTH(WIDTH)) u_skid (
                .clk    (clk),
                .reset  (reset),
                .push_i (in_valid && !skid_full && !adv[0]),
                .pop_i  (adv[0]),
                .kill_i (kill[0]),
                .data_i (in_data),
                .full_o (skid_full),
                .data_o (skid_data)
            );
            assign in_ready = !skid_full;
            assign skid_nf  = !adv[0] && (skid_full || in_valid);
            assign src      = skid_full ? {1'b1, skid_data} : {in_valid, in_data};
        end else begin : g_direct
            assign skid_full = 1'b0;
            assign skid_nf   = 1'b0;
            assign in_ready  = adv[0];
            assign src       = {in_valid, in_data};
        end
    endgenerate

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        stage_t up;
        if (gi == 0) begin : g_head
            assign up = src;
        end else begin : g_body
            assign up = {v_q[gi-1], d_q[gi-1]};
        end
        // A stage may load whenever any stage at or beyond it has room.
        assign adv[gi]  = out_ready || !(&v_q[DEPTH-1:gi]);
        assign v_nf[gi] = adv[gi] ? up.valid : v_q[gi];
        assign v_d[gi]  = v_nf[gi] && !kill[gi];
        assign d_d[gi]  = (adv[gi] && up.valid) ? up.data : d_q[gi];
    end

    // Every item that would survive the edge but sits in a killed slot is a drop.
    always_comb begin
        kill_n      = OW'(skid_nf && kill[0]);
        occupancy_d = OW'(skid_nf && !kill[0]);
        for (int i = 0; i < DEPTH; i++) begin
            kill_n      = kill_n + OW'(v_nf[i] && kill[i]);
            occupancy_d = occupancy_d + OW'(v_d[i]);
        end
        drop_sum   = {1'b0, drop_cnt_q} + (CNT_W+1)'(kill_n);
        drop_cnt_d = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q         <= '0;
            occupancy_q <= '0;
            drop_cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q         <= v_d;
            occupancy_q <= occupancy_d;
            drop_cnt_q  <= drop_cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= d_d[i];
            end
        end
    end

    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign occupancy = occupancy_q;
    assign drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Drives a combinational-ready and a skid-buffered chain with the same stimulus
// and checks both against a slot-shifting reference model every cycle.
module tb_pipe_stage_chain;
    localparam int D  = 4;
    localparam int OW = pipe_pkg::occ_width(D);

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [31:0]   in_data;
    logic          out_ready;
    logic          flush;
    logic [D-1:0]  flush_mask;

    logic          in_ready0, out_valid0, in_ready1, out_valid1;
    logic [31:0]   out_data0, out_data1;
    logic [OW-1:0] occupancy0, occupancy1;
    logic [15:0]   drop0, drop1;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference state per instance: 0 = combinational ready, 1 = skid buffered.
    logic        mv    [2][D];
    logic [31:0] md    [2][D];
    logic        skv   [2];
    logic [31:0] skd   [2];
    int          drops [2];

    pipe_stage_chain #(.WIDTH(32), .DEPTH(D), .REG_READY(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .out_valid(out_valid0), .out_data(out_data0),
        .out_ready(out_ready), .flush(flush), .flush_mask(flush_mask),
        .occupancy(occupancy0), .drop_cnt(drop0)
    );

    pipe_stage_chain #(.WIDTH(32), .DEPTH(D), .REG_READY(1'b1), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
        .out_ready(out_ready), .flush(flush), .flush_mask(flush_mask),
        .occupancy(occupancy1), .drop_cnt(drop1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < D; i++) begin
                mv[k][i] = 1'b0;
                md[k][i] = '0;
            end
            skv[k]   = 1'b0;
            skd[k]   = '0;
            drops[k] = 0;
        end
    endtask

    function automatic logic model_in_ready(input int k);
        logic all_full;
        all_full = 1'b1;
        for (int i = 0; i < D; i++) all_full = all_full & mv[k][i];
        return (k == 1) ? !skv[k] : (out_ready || !all_full);
    endfunction

    function automatic int model_occ(input int k);
        int n;
        n = skv[k] ? 1 : 0;
        for (int i = 0; i < D; i++) n += mv[k][i] ? 1 : 0;
        return n;
    endfunction

    // Items shift forward from the output end into any free slot, the head slot
    // refills from the skid entry or the input, then masked slots are emptied.
    task automatic model_step(input int k);
        logic take;
        take = in_valid && model_in_ready(k);
        if (mv[k][D-1] && out_ready) mv[k][D-1] = 1'b0;
        for (int i = D - 2; i >= 0; i--) begin
            if (mv[k][i] && !mv[k][i+1]) begin
                mv[k][i+1] = 1'b1;
                md[k][i+1] = md[k][i];
                mv[k][i]   = 1'b0;
            end
        end
        if (skv[k]) begin
            if (!mv[k][0]) begin
                mv[k][0] = 1'b1;
                md[k][0] = skd[k];
                skv[k]   = 1'b0;
            end
        end else if (take) begin
            if (!mv[k][0]) begin
                mv[k][0] = 1'b1;
                md[k][0] = in_data;
            end else begin
                skv[k] = 1'b1;
                skd[k] = in_data;
            end
        end
        if (flush) begin
            for (int i = 0; i < D; i++) begin
                if (flush_mask[i] && mv[k][i]) begin
                    drops[k]++;
                    mv[k][i] = 1'b0;
                end
            end
            if (flush_mask[0] && skv[k]) begin
                drops[k]++;
                skv[k] = 1'b0;
            end
        end
        if (drops[k] > 65535) drops[k] = 65535;
    endtask

    task automatic check_all();
        chk("in_ready0",  32'(in_ready0),  32'(model_in_ready(0)));
        chk("out_valid0", 32'(out_valid0), 32'(mv[0][D-1]));
        if (mv[0][D-1]) chk("out_data0", out_data0, md[0][D-1]);
        chk("occupancy0", 32'(occupancy0), model_occ(0));
        chk("drop_cnt0",  32'(drop0),      drops[0]);
        chk("in_ready1",  32'(in_ready1),  32'(model_in_ready(1)));
        chk("out_valid1", 32'(out_valid1), 32'(mv[1][D-1]));
        if (mv[1][D-1]) chk("out_data1", out_data1, md[1][D-1]);
        chk("occupancy1", 32'(occupancy1), model_occ(1));
        chk("drop_cnt1",  32'(drop1),      drops[1]);
    endtask

    // Called at a falling edge: drive, check the settled outputs, advance the model, clock.
    task automatic cycle(input logic iv, input logic [31:0] id, input logic ordy,
                         input logic fl, input logic [D-1:0] fm);
        in_valid   = iv;
        in_data    = id;
        out_ready  = ordy;
        flush      = fl;
        flush_mask = fm;
        #1;
        check_all();
        model_step(0);
        model_step(1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b0, '0);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_out_valid0"}, 32'(out_valid0), 32'h0);
        chk({tag, "_out_data0"},  out_data0,       32'h0);
        chk({tag, "_in_ready0"},  32'(in_ready0),  32'h1);
        chk({tag, "_occ0"},       32'(occupancy0), 32'h0);
        chk({tag, "_drop0"},      32'(drop0),      32'h0);
        chk({tag, "_out_valid1"}, 32'(out_valid1), 32'h0);
        chk({tag, "_in_ready1"},  32'(in_ready1),  32'h1);
        chk({tag, "_occ1"},       32'(occupancy1), 32'h0);
        chk({tag, "_drop1"},      32'(drop1),      32'h0);
    endtask

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        flush      = 1'b0;
        flush_mask = '0;
        model_reset();
        #1;
        check_cleared("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Back-to-back stream with a free-running sink.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 32'(i + 1), 1'b1, 1'b0, '0);
            if (i == 3) begin
                chk("lat_valid0", 32'(out_valid0), 32'h1);
                chk("lat_data0",  out_data0,       32'h1);
                chk("lat_valid1", 32'(out_valid1), 32'h1);
                chk("lat_data1",  out_data1,       32'h1);
            end
            if (i >= 3) chk("stream_occ0", 32'(occupancy0), 32'h4);
        end
        drain();

        // Fill then stall the sink; the skid chain also grabs one extra item.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'hA + 32'(i), 1'b0, 1'b0, '0);
        chk("full_in_ready0", 32'(in_ready0), 32'h0);
        repeat (5) cycle(1'b1, 32'hE0, 1'b0, 1'b0, '0);
        chk("stall_data0",  out_data0,       32'hA);
        chk("stall_valid0", 32'(out_valid0), 32'h1);
        drain();

        // Bubble collapse under back-pressure.
        cycle(1'b1, 32'h11, 1'b0, 1'b0, '0);
        cycle(1'b0, 32'h0,  1'b0, 1'b0, '0);
        cycle(1'b0, 32'h0,  1'b0, 1'b0, '0);
        cycle(1'b1, 32'h22, 1'b0, 1'b0, '0);
        repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b0, '0);
        chk("bubble_occ0",      32'(occupancy0), 32'h2);
        chk("bubble_in_ready0", 32'(in_ready0),  32'h1);
        chk("bubble_out0",      out_data0,       32'h11);
        drain();

        // Selective flush of the two middle stages of a full chain.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'(i + 1), 1'b0, 1'b0, '0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 4'b0110);
        chk("flush_drop0", 32'(drop0),      32'h2);
        chk("flush_occ0",  32'(occupancy0), 32'h2);
        chk("flush_out0",  out_data0,       32'h1);
        chk("flush_drop1", 32'(drop1),      32'h2);
        drain();

        // Fifth item lands in the skid entry, then stage 0 and skid are flushed.
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h51 + 32'(i), 1'b0, 1'b0, '0);
        chk("skid_in_ready1", 32'(in_ready1),  32'h0);
        chk("skid_occ1",      32'(occupancy1), 32'h5);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 4'b0001);
        chk("skid_drop1",     32'(drop1),      32'h4);
        chk("skid_occ_post1", 32'(occupancy1), 32'h3);
        chk("skid_ready_post1", 32'(in_ready1), 32'h1);
        chk("skid_drop0",     32'(drop0),      32'h3);
        drain();

        // Random traffic, back-pressure and flushes.
        repeat (400) begin
            cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 7) == 0), D'($urandom_range(0, 15)));
        end
        drain();

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'hC0 + 32'(i), 1'b1, 1'b0, '0);
        #3 reset = 1'b0;
        #1;
        check_cleared("async_reset");
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b1, 32'hEE, 1'b1, 1'b0, '0);
        repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0, '0);
        chk("post_reset_valid0", 32'(out_valid0), 32'h1);
        chk("post_reset_data0",  out_data0,       32'hEE);
        chk("post_reset_valid1", 32'(out_valid1), 32'h1);
        chk("post_reset_data1",  out_data1,       32'hEE);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
